// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Oversamples the line, samples mid-bit and flags parity and framing errors.
module xor_parity_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic             ODD_BIT   = (ODD_PARITY != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic              rx_meta;
    logic              rx_s;
    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;
    logic              acc;
    logic              perr;

    // Synchronizer presets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            acc        <= 1'b0;
            perr       <= 1'b0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        shreg <= '0;
                        acc   <= 1'b0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        acc        <= acc ^ rx_s;
                        if (idx == IDX_LAST) begin
                            state <= S_PARITY;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        perr  <= ((acc ^ rx_s) != ODD_BIT);
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        valid_out  <= 1'b1;
                        data_out   <= shreg;
                        parity_err <= perr;
                        frame_err  <= ~rx_s;
                        state      <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A held-low line must return high before a new start is looked for.
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_xor_parity_rx.sv
// Testbench for xor_parity_rx: directed and random frames against a
// scoreboard fed by a frame-level reference model.
module tb_xor_parity_rx;

    localparam int CPB = 16;
    localparam int DW  = 8;
    // two synchronizer flops plus the IDLE detect edge, then mid-bit sampling to the stop bit
    localparam int LAT = 3 + CPB / 2 + (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_in = 1'b1;
    logic          rx_odd = 1'b1;
    logic [DW-1:0] data_out, data_odd;
    logic          valid_out, valid_odd;
    logic          parity_err, perr_odd;
    logic          frame_err, ferr_odd;
    logic          busy, busy_odd;

    xor_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(data_out),
        .valid_out(valid_out), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    xor_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_odd), .data_out(data_odd),
        .valid_out(valid_odd), .parity_err(perr_odd), .frame_err(ferr_odd), .busy(busy_odd)
    );

    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt++;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        int            due;
    } exp_t;

    exp_t expQ[$];
    exp_t expOddQ[$];
    int   numChecks = 0;
    int   numErrors = 0;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycleCnt);
        end
    endtask

    task automatic setLine(input bit toOdd, input logic b);
        if (toOdd) rx_odd = b;
        else       rx_in  = b;
    endtask

    // Model: a frame is judged purely from its bit contents and arrival time.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic pbit, input logic stopBit,
                                 input int lowTail, input bit toOdd);
        exp_t e;
        logic [DW+2:0] frame;
        int oddFlag;
        oddFlag = toOdd ? 1 : 0;
        e.data  = d;
        e.perr  = ((($countones(d) + int'(pbit)) % 2) != oddFlag);
        e.ferr  = ~stopBit;
        e.due   = cycleCnt + LAT;
        if (toOdd) expOddQ.push_back(e);
        else       expQ.push_back(e);
        frame = {stopBit, pbit, d, 1'b0};
        for (int i = 0; i < DW + 3; i++) begin
            setLine(toOdd, frame[i]);
            repeat (CPB) @(negedge clk);
        end
        if (!stopBit) begin
            repeat (lowTail) @(negedge clk);
            setLine(toOdd, 1'b1);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic checkOutput(input bit which, input logic [DW-1:0] d, input logic pe, input logic fe);
        exp_t e;
        bit   empty;
        empty = which ? (expOddQ.size() == 0) : (expQ.size() == 0);
        if (empty) begin
            numChecks++;
            numErrors++;
            $display("[TB] FAIL unexpected_valid (dut %0d): got data %0h, expected no frame", which, d);
        end else begin
            e = which ? expOddQ.pop_front() : expQ.pop_front();
            checkEq(which ? "odd_data" : "data", 32'(d), 32'(e.data));
            checkEq(which ? "odd_parity_err" : "parity_err", 32'(pe), 32'(e.perr));
            checkEq(which ? "odd_frame_err" : "frame_err", 32'(fe), 32'(e.ferr));
            numChecks++;
            if (cycleCnt < e.due - 2 || cycleCnt > e.due + 2) begin
                numErrors++;
                $display("[TB] FAIL latency (dut %0d): got cycle %0d expected %0d", which, cycleCnt, e.due);
            end
        end
    endtask

    logic prevValid = 1'b0;
    logic prevValidOdd = 1'b0;

    always @(negedge clk) begin
        if (valid_out) begin
            checkOutput(1'b0, data_out, parity_err, frame_err);
            numChecks++;
            if (prevValid) begin
                numErrors++;
                $display("[TB] FAIL pulse_width: got valid_out high 2+ cycles, expected 1");
            end
        end
        prevValid = valid_out;
    end

    always @(negedge clk) begin
        if (valid_odd) begin
            checkOutput(1'b1, data_odd, perr_odd, ferr_odd);
            numChecks++;
            if (prevValidOdd) begin
                numErrors++;
                $display("[TB] FAIL odd_pulse_width: got valid high 2+ cycles, expected 1");
            end
        end
        prevValidOdd = valid_odd;
    end

    initial begin
        logic [DW-1:0] d;
        logic          pbit;
        logic          stopBit;
        int            gap;

        repeat (3) @(negedge clk);
        checkEq("reset_data", 32'(data_out), 32'h0);
        checkEq("reset_valid", 32'(valid_out), 32'h0);
        checkEq("reset_parity_err", 32'(parity_err), 32'h0);
        checkEq("reset_frame_err", 32'(frame_err), 32'h0);
        checkEq("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] clean frame 0xA5 and wrong-parity frame 0x01");
        applyStimulus(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        repeat (5) @(negedge clk);
        checkEq("busy_after_frame", 32'(busy), 32'h0);
        applyStimulus(8'h01, 1'b0, 1'b1, 0, 1'b0);
        repeat (5) @(negedge clk);

        $display("[TB] 4-clock glitch");
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        checkEq("glitch_busy_high", 32'(busy), 32'h1);
        repeat (7) @(negedge clk);
        checkEq("glitch_busy_dropped", 32'(busy), 32'h0);
        repeat (10) @(negedge clk);

        $display("[TB] framing error with held-low line, then clean 0x55");
        applyStimulus(8'h3C, 1'b0, 1'b0, 40, 1'b0);
        repeat (20) @(negedge clk);
        applyStimulus(8'h55, 1'b0, 1'b1, 0, 1'b0);
        repeat (5) @(negedge clk);

        $display("[TB] reset during data bit 4");
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkEq("midreset_data", 32'(data_out), 32'h0);
        checkEq("midreset_valid", 32'(valid_out), 32'h0);
        checkEq("midreset_parity_err", 32'(parity_err), 32'h0);
        checkEq("midreset_frame_err", 32'(frame_err), 32'h0);
        checkEq("midreset_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkEq("post_reset_busy", 32'(busy), 32'h0);
        applyStimulus(8'hFF, 1'b0, 1'b1, 0, 1'b0);
        repeat (5) @(negedge clk);

        $display("[TB] back-to-back 0x00 / 0xFF and odd-parity frame");
        applyStimulus(8'h00, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 0, 1'b1);
        repeat (5) @(negedge clk);

        $display("[TB] random frames");
        for (int k = 0; k < 24; k++) begin
            d       = DW'($urandom_range(0, 255));
            pbit    = (($countones(d) % 2) == 1);
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            stopBit = ($urandom_range(0, 7) != 0);
            gap     = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
            applyStimulus(d, pbit, stopBit, int'($urandom_range(0, 30)), 1'b0);
            repeat (gap) @(negedge clk);
        end

        for (int t = 0; t < 400 && (expQ.size() != 0 || expOddQ.size() != 0); t++) begin
            @(negedge clk);
        end
        while (expQ.size() != 0) begin
            numChecks++;
            numErrors++;
            $display("[TB] FAIL missing_frame: got no valid_out, expected data %0h", expQ[0].data);
            void'(expQ.pop_front());
        end
        while (expOddQ.size() != 0) begin
            numChecks++;
            numErrors++;
            $display("[TB] FAIL odd_missing_frame: got no valid_out, expected data %0h", expOddQ[0].data);
            void'(expOddQ.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
